p4_mp_seq: RTL
==============

# p4_mp_seq

Multi-precision add sequencer that sits directly upstream and downstream of the combinational P4 adder. It accepts a word-serial stream of operand pairs and drives each pair into the adder with a registered carry-in. It samples the adder's sum and carry-out one cycle later and emits a word-serial sum stream. The carry-out of each word is chained into the carry-in of the next word, so operands wider than DWIDTH are added with a single DWIDTH-bit P4 instance.

## Interface
- DWIDTH, 32, data width; must equal the P4 adder width.
- CNT_W, 8, width of the per-operation word index.

Clock, reset and streams:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  block can accept an operand word.
- in_a  in  DWIDTH  operand A word, least-significant word first.
- in_b  in  DWIDTH  operand B word.
- in_cin  in  1  carry-in of the operation; sampled only on the first word.
- in_last  in  1  marks the most-significant word of the operation.

P4 adder side:
- p4_a  out  DWIDTH  registered A to the adder.
- p4_b  out  DWIDTH  registered B to the adder.
- p4_cin  out  1  registered carry-in to the adder.
- p4_s  in  DWIDTH  adder combinational sum.
- p4_cout  in  1  adder combinational carry-out.

Result stream:
- out_valid  out  1  sum word valid.
- out_ready  in  1  consumer accepts the sum word.
- out_sum  out  DWIDTH  sum word.
- out_last  out  1  final word of the operation.
- out_cout  out  1  final carry-out; meaningful only when out_last=1, otherwise 0.
- out_idx  out  CNT_W  word index within the operation.

## Operation
The state machine has three states.

- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid: register in_a, in_b onto p4_a, p4_b.
  - p4_cin <= first_r ? in_cin : carry_r.
  - Latch in_last into last_r and go to EVAL.
- **EVAL**
  - in_ready=0, out_valid=0.
  - The adder settles on the registered inputs.
  - At the end of the cycle: out_sum <= p4_s, carry_r <= p4_cout.
  - out_last <= last_r, out_cout <= last_r ? p4_cout : 0.
  - Go to HOLD.
- **HOLD**
  - out_valid=1, in_ready=0.
  - out_sum, out_last, out_cout and out_idx are held stable until out_valid && out_ready.
  - On that handshake, go to IDLE.
  - If out_last: first_r <= 1 and idx_r <= 0.
  - Otherwise: first_r <= 0 and idx_r <= idx_r+1.

Registers and output rules:
- first_r is 1 after reset and after every completed operation.
- carry_r is used as the carry-in only when first_r=0.
- idx_r wraps modulo 2^CNT_W; it does not saturate and raises no error.
- p4_a, p4_b and p4_cin hold their last values outside EVAL; they change only on an input handshake.
- in_ready is a decode of the state only, with no combinational path from out_ready.
- out_valid is registered.
- All sum arithmetic is performed by the P4. The block adds no logic on the sum path.

Reset:
- All outputs go to 0: in_ready, out_valid, out_sum, out_last, out_cout, out_idx, p4_a, p4_b, p4_cin.
- state=IDLE, first_r=1, carry_r=0, idx_r=0.
- in_ready rises in the first cycle after rst deasserts.
- Reset mid-operation, in any state, aborts the operation:
  - a pending result is discarded, not emitted;
  - the chained carry is cleared;
  - the next accepted word is treated as a first word.

## Timing
- Input handshake at edge T. p4_* are valid in cycle T+1 (EVAL). out_valid=1 from cycle T+2.
- Latency is 2 cycles from input accept to out_valid.
- With out_ready held at 1, the output handshake completes in T+2 and in_ready=1 in T+3. Throughput is 1 word per 3 cycles.
- Backpressure: each cycle of out_ready=0 in HOLD adds one cycle. in_ready stays 0 throughout.
- The adder's combinational path is given one full cycle (EVAL) from registered p4_* to capture.
- in_cin on non-first words and in_* while in_ready=0 are ignored.

## Test plan
- **Single-word overflow.** Reset, then one word A=0xFFFFFFFF, B=0x00000001, cin=0, last=1. Required: out_sum=0x00000000, out_cout=1, out_last=1, out_idx=0, out_valid exactly 2 cycles after accept.
- **Two-word carry chain.** Word 0: A=0xFFFFFFFF, B=0x00000001, cin=0. Word 1: A=0, B=0, last=1. Required: sums 0x00000000 then 0x00000001, p4_cin=1 on word 1, final out_cout=0, out_idx 0 then 1.
- **Carry-in scope.** Word 0: A=5, B=6, cin=1. Word 1: A=1, B=1, cin=1, last. Required: sums 0x0000000C then 0x00000002; cin on word 1 ignored.
- **Backpressure.** out_ready=0 for 5 cycles during HOLD. Required: out_sum, out_idx and out_valid stable; in_ready=0; no new p4_a change; resumes on out_ready=1.
- **Reset mid-operation.** Assert rst in EVAL of word 1 of a 3-word operation. Required: no output emitted; all outputs 0 next cycle; next word uses in_cin and out_idx=0.
- **Index wrap.** CNT_W=2, 5-word operation. Required: out_idx sequence 0, 1, 2, 3, 0, with out_last only on the fifth word.

Source files
------------

// File: rtl/p4_mp_seq.sv
// Word-serial multi-precision add sequencer around an external combinational P4 adder.
// Each word pair is registered into the adder, and the sum and carry are captured one cycle later.
module p4_mp_seq #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
  output logic [DWIDTH-1:0] p4_a,
  output logic [DWIDTH-1:0] p4_b,
  output logic              p4_cin,
  input  logic [DWIDTH-1:0] p4_s,
  input  logic              p4_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic [CNT_W-1:0]  out_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               first_r;
  logic               carry_r;
  logic               last_r;
  logic [CNT_W-1:0]   idx_r;
  logic               accept;
  logic               out_hs;

  assign accept = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = EVAL;
        else        state_next = IDLE;
      end
      EVAL: state_next = HOLD;
      HOLD: begin
        if (out_hs) state_next = IDLE;
        else        state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake flags are registered decodes of the upcoming state, so in_ready
  // stays low through the reset cycle and never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p4_a    <= {DWIDTH{1'b0}};
      p4_b    <= {DWIDTH{1'b0}};
      p4_cin  <= 1'b0;
      last_r  <= 1'b0;
    end else if (accept) begin
      p4_a    <= in_a;
      p4_b    <= in_b;
      p4_cin  <= first_r ? in_cin : carry_r;
      last_r  <= in_last;
    end
  end

  // Capture the settled adder result; the carry is chained to the next word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum  <= {DWIDTH{1'b0}};
      out_last <= 1'b0;
      out_cout <= 1'b0;
      out_idx  <= {CNT_W{1'b0}};
      carry_r  <= 1'b0;
    end else if (state == EVAL) begin
      out_sum  <= p4_s;
      out_last <= last_r;
      out_cout <= last_r ? p4_cout : 1'b0;
      out_idx  <= idx_r;
      carry_r  <= p4_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_r <= 1'b1;
      idx_r   <= {CNT_W{1'b0}};
    end else if ((state == HOLD) && out_hs) begin
      if (out_last) begin
        first_r <= 1'b1;
        idx_r   <= {CNT_W{1'b0}};
      end else begin
        first_r <= 1'b0;
        idx_r   <= idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
